// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels in front of a
// byte-lane-writable word SRAM, with WAIT_CYCLES wait states. Optional macro: DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wea_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wea_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp, in_range, misalign, acc_ok, mem_we;
  logic [31:0]   acc_addr, acc_wdata, off;
  logic [3:0]    acc_wea;
  logic [IW-1:0] idx;
  logic          unused_off;

  assign accept     = req_valid_i && req_ready_o;
  assign enter_resp = (state_q == S_IDLE && accept && WAIT_CYCLES == 0) ||
                      (state_q == S_WAIT && cnt_q == 4'd1);

  // With zero wait states the access uses the request as it is being accepted.
  assign acc_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
  assign acc_wea   = (state_q == S_IDLE) ? req_wea_i   : wea_q;

  assign off        = acc_addr - ADDR_BASE;
  assign in_range   = off < SPAN;
  assign idx        = off[IW+1:2];
  assign unused_off = ^{off[31:IW+2], off[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  logic [1:0] lead;
  always_comb begin
    lead = 2'd3;
    if (acc_wea[0])      lead = 2'd0;
    else if (acc_wea[1]) lead = 2'd1;
    else if (acc_wea[2]) lead = 2'd2;
  end
  assign misalign = (acc_addr[1:0] != 2'd0 && (acc_wea == 4'h0 || acc_wea == 4'hF)) ||
                    (acc_addr[0] && (acc_wea == 4'h3 || acc_wea == 4'hC)) ||
                    (acc_wea != 4'h0 && lead != acc_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign acc_ok = in_range && !misalign;
  assign mem_we = enter_resp && acc_ok && (acc_wea != 4'h0);

  // Array is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (acc_wea[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wea_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wea_q   <= req_wea_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) state_d = S_RESP;
        else begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: if (resp_ready_i) begin
        state_d = S_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (acc_ok && acc_wea == 4'h0) ? mem[idx] : 32'h0;
      err_d   = !acc_ok;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_RESP);
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel. Internally it is a word-organised SRAM array with byte-lane write enables. A programmable number of wait states models slower memory. It sits between the CPU's memory-access stage and backing storage, and replaces the zero-latency combinational data port.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=4)
ADDR_BASE, 32'h0000_0000, byte address mapped to word 0 (word-aligned)
WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_wdata  input  32  store data, already lane-aligned by the requester
req_wea  input  4  byte-lane write enables; 4'h0 = word read
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  32  full word read data; 0 for stores and errors
resp_err  output  1  access error (out of range, or misaligned when checking is enabled)

Behaviour:
- Reset (async assert, sync release): FSM returns to IDLE and the wait counter clears. Output reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not reset and are preserved across reset.
- FSM states are IDLE, WAIT and RESP. req_ready=1 only in IDLE. resp_valid=1 only in RESP.
- IDLE: on req_valid&&req_ready, latch addr, wdata and wea. If WAIT_CYCLES==0 go to RESP; otherwise load cnt=WAIT_CYCLES and go to WAIT.
- WAIT: cnt decrements each cycle. When cnt==1, go to RESP on the next edge.
- Array access happens on the edge that enters RESP:
  - Compute off = addr - ADDR_BASE.
  - In range means off < DEPTH_WORDS*4, unsigned 32-bit. This includes wrap, so addr < ADDR_BASE is out of range.
  - Word index is off[..:2]. addr[1:0] is ignored unless the optional feature is enabled.
  - In-range store: write only the lanes set in wea (lane i = bits 8i+7:8i). resp_rdata=0, resp_err=0.
  - In-range read (wea==0): resp_rdata=array[index], resp_err=0.
  - Out of range: no write, resp_rdata=0, resp_err=1.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE and clear resp_rdata and resp_err.
- Latency: request accepted at edge N gives resp_valid high after edge N+1+WAIT_CYCLES. With immediate resp_ready, throughput is one transaction per 2+WAIT_CYCLES cycles.
- Only one transaction is outstanding at a time. A request arriving while not in IDLE is not accepted, and the requester must hold it.
- Read after write to the same word returns the updated data.
- A partial-lane store leaves the other bytes unchanged.
- Reset during WAIT: the transaction is dropped and no write occurs.
- Reset during RESP: the write has already committed and the response is dropped.
- resp_ready asserted outside RESP is ignored.

Optional Feature:
DMEM_MISALIGN_CHK_EN
- Defined: a request is flagged misaligned when any of the following holds:
  - addr[1:0]!=0 with wea==4'h0 or wea==4'hF;
  - addr[0]==1 with wea==4'h3 or wea==4'hC;
  - the set lanes do not start at lane addr[1:0].
  A misaligned request is treated like out of range: no write, resp_rdata=0, resp_err=1. The checks run in RESP-entry logic, so latency is unchanged.
- Undefined: addr[1:0] is ignored, and the error logic reduces to the range check only.

Test Plan:
1. WAIT_CYCLES=1: store addr 0x10, wdata 0xDEADBEEF, wea 4'hF accepted at cycle 0. Then read addr 0x10 → resp_valid at cycle 2 for each transaction; read returns 0xDEADBEEF, err=0.
2. Store 0x000000AA to 0x10 with wea 4'h1 over word 0xDEADBEEF, then read 0x10 → 0xDEADBEAA.
3. Read addr ADDR_BASE+DEPTH_WORDS*4 (0x1000 at defaults) → resp_rdata=0, resp_err=1. Store to the same address → err=1 and the array is unchanged (verified by reading 0xFFC).
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, rdata and err stay stable, req_ready=0. A second req_valid is not accepted until the cycle after the response handshake.
5. Assert rst_n=0 during WAIT of a store to 0x20 (prior content 0x11111111) → outputs return to reset values asynchronously. A post-reset read of 0x20 returns 0x11111111.
6. DMEM_MISALIGN_CHK_EN defined: word read at 0x12 → err=1, rdata=0; store wea 4'hC at 0x12 → err=0, upper halfword written. Undefined: the read at 0x12 returns word 0x10 with err=0.
